// File: rtl/data_path.sv
// data_path: 16x16 register file, 256x16 data memory, 8-function ALU and write-back mux.
// All sequencing (addresses, enables, ALU select) comes from the external controller.
module data_path #(
   localparam int unsigned DW   = 16,
   localparam int unsigned MAW  = 8,
   localparam int unsigned RAW  = 4,
   localparam int unsigned SW   = 3,
   localparam int unsigned NREG = 1 << RAW,
   localparam int unsigned NMEM = 1 << MAW
) (
   input  logic           Clock,
   input  logic           n_rst,
   input  logic [MAW-1:0] D_Addr,
   input  logic           D_Wr,
   input  logic           RF_s,
   input  logic [RAW-1:0] RF_W_Addr,
   input  logic           RF_W_en,
   input  logic [RAW-1:0] RF_Ra_Addr,
   input  logic [RAW-1:0] RF_Rb_Addr,
   input  logic [SW-1:0]  ALU_s0,
   output logic [DW-1:0]  ALU_inA,
   output logic [DW-1:0]  ALU_inB,
   output logic [DW-1:0]  ALU_out,
   output logic           zero_flag
);

   localparam logic [SW-1:0] OP_ZERO = 3'b000;
   localparam logic [SW-1:0] OP_ADD  = 3'b001;
   localparam logic [SW-1:0] OP_SUB  = 3'b010;
   localparam logic [SW-1:0] OP_PASS = 3'b011;
   localparam logic [SW-1:0] OP_XOR  = 3'b100;
   localparam logic [SW-1:0] OP_OR   = 3'b101;
   localparam logic [SW-1:0] OP_AND  = 3'b110;
   localparam logic [SW-1:0] OP_INC  = 3'b111;

   logic [DW-1:0] rf_q  [NREG];
   logic [DW-1:0] mem_q [NMEM];
   logic [DW-1:0] dout_q;
   logic [DW-1:0] wb_d;
   logic [DW-1:0] alu_c;

   // Combinational read ports; reset clears the array so both read 0 during reset
   assign ALU_inA = rf_q[RF_Ra_Addr];
   assign ALU_inB = rf_q[RF_Rb_Addr];

   always_comb begin
      alu_c = '0;
      case (ALU_s0)
         OP_ZERO: alu_c = '0;
         OP_ADD:  alu_c = ALU_inA + ALU_inB;
         OP_SUB:  alu_c = ALU_inA - ALU_inB;
         OP_PASS: alu_c = ALU_inA;
         OP_XOR:  alu_c = ALU_inA ^ ALU_inB;
         OP_OR:   alu_c = ALU_inA | ALU_inB;
         OP_AND:  alu_c = ALU_inA & ALU_inB;
         OP_INC:  alu_c = ALU_inA + DW'(1);
         default: alu_c = '0;
      endcase
   end

   assign ALU_out   = alu_c;
   assign zero_flag = (alu_c == '0);

   // Write-back source: ALU result or the registered memory read
   assign wb_d = RF_s ? alu_c : dout_q;

   // Data array has no reset so its contents survive n_rst; stores are blocked during reset
   always_ff @(posedge Clock) begin
      if (n_rst && D_Wr) begin
         mem_q[D_Addr] <= ALU_inA;
      end
   end

   // Registered read returns pre-write contents on a same-address store
   always_ff @(posedge Clock or negedge n_rst) begin
      if (!n_rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= mem_q[D_Addr];
      end
   end

   always_ff @(posedge Clock or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (RF_W_en) begin
         rf_q[RF_W_Addr] <= wb_d;
      end
   end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: driver pushes model-predicted outputs, monitor pops and compares.
// Directed checks follow the documented scenarios; a random phase exercises the rest.
module tb_data_path;

   logic        Clock = 1'b0;
   logic        n_rst = 1'b0;
   logic [7:0]  D_Addr = '0;
   logic        D_Wr = 1'b0;
   logic        RF_s = 1'b0;
   logic [3:0]  RF_W_Addr = '0;
   logic        RF_W_en = 1'b0;
   logic [3:0]  RF_Ra_Addr = '0;
   logic [3:0]  RF_Rb_Addr = '0;
   logic [2:0]  ALU_s0 = '0;
   logic [15:0] ALU_inA;
   logic [15:0] ALU_inB;
   logic [15:0] ALU_out;
   logic        zero_flag;

   always #5 Clock = ~Clock;

   data_path dut (
      .Clock      (Clock),
      .n_rst      (n_rst),
      .D_Addr     (D_Addr),
      .D_Wr       (D_Wr),
      .RF_s       (RF_s),
      .RF_W_Addr  (RF_W_Addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_Addr (RF_Ra_Addr),
      .RF_Rb_Addr (RF_Rb_Addr),
      .ALU_s0     (ALU_s0),
      .ALU_inA    (ALU_inA),
      .ALU_inB    (ALU_inB),
      .ALU_out    (ALU_out),
      .zero_flag  (zero_flag)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] o;
      logic        z;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state: architectural registers, memory words and the read latch
   logic [15:0] m_rf  [16];
   logic [15:0] m_mem [256];
   logic [15:0] m_dout;

   function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      int unsigned s;
      case (op)
         3'd0:    s = 0;
         3'd1:    s = int'(a) + int'(b);
         3'd2:    s = 32'h10000 + int'(a) - int'(b);
         3'd3:    s = int'(a);
         3'd4:    s = int'(a ^ b);
         3'd5:    s = int'(a | b);
         3'd6:    s = int'(a & b);
         default: s = int'(a) + 1;
      endcase
      return 16'(s % 65536);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_dout = '0;
   endtask

   // Monitor: outputs are combinational, sampled shortly after the driver settles inputs
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got sample with no expectation at %0t", $time);
         end else begin
            e = q.pop_front();
            check("sb_inA", ALU_inA, e.a);
            check("sb_inB", ALU_inB, e.b);
            check("sb_out", ALU_out, e.o);
            check("sb_zero", 16'(zero_flag), 16'(e.z));
         end
      end
   end

   // One clock of stimulus: drive at negedge, predict outputs, then advance the model past the edge
   task automatic step(input logic rst_v, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [2:0] op, input logic rfs, input logic wen,
                       input logic [3:0] wa, input logic [7:0] da, input logic dwr);
      exp_t        e;
      logic [15:0] mux;
      logic [15:0] nd;
      @(negedge Clock);
      n_rst      = rst_v;
      RF_Ra_Addr = ra;
      RF_Rb_Addr = rb;
      ALU_s0     = op;
      RF_s       = rfs;
      RF_W_en    = wen;
      RF_W_Addr  = wa;
      D_Addr     = da;
      D_Wr       = dwr;
      if (!rst_v) model_reset();
      e.a = m_rf[ra];
      e.b = m_rf[rb];
      e.o = ref_alu(op, e.a, e.b);
      e.z = (e.o == 16'h0000);
      q.push_back(e);
      ->sample_ev;
      if (rst_v) begin
         mux = rfs ? e.o : m_dout;
         nd  = m_mem[da];
         if (dwr) m_mem[da] = e.a;
         if (wen) m_rf[wa] = mux;
         m_dout = nd;
      end
   endtask

   // Build an arbitrary constant in register r by doubling and incrementing
   task automatic load_const(input logic [3:0] r, input logic [15:0] v);
      step(1'b1, r, r, 3'd0, 1'b1, 1'b1, r, 8'd0, 1'b0);
      for (int i = 15; i >= 0; i--) begin
         step(1'b1, r, r, 3'd1, 1'b1, 1'b1, r, 8'd0, 1'b0);
         if (v[i]) step(1'b1, r, r, 3'd7, 1'b1, 1'b1, r, 8'd0, 1'b0);
      end
   endtask

   // Reset asserted between edges with whatever inputs are currently applied
   task automatic async_reset();
      exp_t e;
      @(negedge Clock);
      #2;
      n_rst = 1'b0;
      model_reset();
      e.a = '0;
      e.b = '0;
      e.o = ref_alu(ALU_s0, 16'h0, 16'h0);
      e.z = (e.o == 16'h0000);
      q.push_back(e);
      ->sample_ev;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [2:0] lops [5];
      logic [15:0] lexp [5];
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      model_reset();

      // Reset, then increment R2
      step(1'b0, 4'd2, 4'd0, 3'd7, 1'b1, 1'b1, 4'd2, 8'd0, 1'b0);
      #2 check("rst_inA", ALU_inA, 16'h0);
      check("rst_out", ALU_out, 16'h1);

      for (int i = 0; i < 256; i++)
         step(1'b1, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 8'(i), 1'b1);

      step(1'b1, 4'd2, 4'd0, 3'd7, 1'b1, 1'b1, 4'd2, 8'd0, 1'b0);
      step(1'b1, 4'd2, 4'd0, 3'd7, 1'b1, 1'b1, 4'd2, 8'd0, 1'b0);
      #2 check("inc1_out", ALU_out, 16'd2);
      // Store R2 to mem[1]; R2 is now 2
      step(1'b1, 4'd2, 4'd0, 3'd7, 1'b1, 1'b0, 4'd2, 8'd1, 1'b1);
      #2 check("inc2_out", ALU_out, 16'd3);
      // Load mem[1] into R1 over two edges
      step(1'b1, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 8'd1, 1'b0);
      step(1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd1, 8'd1, 1'b0);
      // Add R1+R2 into R4
      step(1'b1, 4'd1, 4'd2, 3'd1, 1'b1, 1'b1, 4'd4, 8'd0, 1'b0);
      #2 check("load_R1", ALU_inA, 16'd2);
      check("add_out", ALU_out, 16'd4);
      step(1'b1, 4'd4, 4'd4, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      #2 check("add_R4", ALU_inA, 16'd4);
      check("sub_eq_out", ALU_out, 16'h0);
      check("sub_eq_zero", 16'(zero_flag), 16'h1);
      step(1'b1, 4'd0, 4'd0, 3'd7, 1'b1, 1'b1, 4'd6, 8'd0, 1'b0);
      step(1'b1, 4'd0, 4'd6, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      #2 check("sub_wrap_out", ALU_out, 16'hFFFF);
      check("sub_wrap_zero", 16'(zero_flag), 16'h0);

      // Logic ops on F0F0 / FF00
      load_const(4'd7, 16'hF0F0);
      load_const(4'd8, 16'hFF00);
      lops[0] = 3'd4; lexp[0] = 16'h0FF0;
      lops[1] = 3'd5; lexp[1] = 16'hFFF0;
      lops[2] = 3'd6; lexp[2] = 16'hF000;
      lops[3] = 3'd3; lexp[3] = 16'hF0F0;
      lops[4] = 3'd0; lexp[4] = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd7, 4'd8, lops[i], 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
         #2 check($sformatf("logic_op%0d", lops[i]), ALU_out, lexp[i]);
      end
      check("logic_zero", 16'(zero_flag), 16'h1);

      // Random traffic; mem[0..15] kept untouched so mem[1] still holds 2 afterwards
      for (int i = 0; i < 400; i++)
         step(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), 8'($urandom_range(16, 255)), 1'($urandom_range(0, 3) == 0));

      // Asynchronous reset with a nonzero register selected on both ports
      load_const(4'd9, 16'h1234);
      step(1'b1, 4'd9, 4'd9, 3'd3, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      async_reset();
      #2 check("arst_inA", ALU_inA, 16'h0);
      check("arst_inB", ALU_inB, 16'h0);
      step(1'b1, 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 8'd1, 1'b0);
      step(1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd3, 8'd1, 1'b0);
      step(1'b1, 4'd3, 4'd9, 3'd3, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
      #2 check("mem_retained", ALU_inA, 16'd2);
      check("arst_R9", ALU_inB, 16'h0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clock);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
